// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative multiply/divide unit, one bit per clock, results in HI/LO
// Define MDU_DIVIDE_EN to build the DIVU/DIV datapath; without it only MULTU/MULT are accepted.
module mult_div_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] HI,
  output logic [N-1:0] LO,
  output logic         busy,
  output logic         done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [5:0]     cnt;
  logic [N-1:0]   opnd;     // |A| for multiply, |B| for divide
  logic [N:0]     acc_hi;   // partial product high half, or partial remainder
  logic [N-1:0]   acc_lo;   // multiplier bits, or dividend bits shifting into quotient
  logic           neg_res;
  logic           op_ok, accept, last;
  logic [N-1:0]   mag_a_in, mag_b_in;
  logic [N:0]     mul_sum;
  logic [2*N-1:0] prod;
  logic [N:0]     it_hi;
  logic [N-1:0]   it_lo, res_hi, res_lo;

  assign mag_a_in = (op[0] && A[N-1]) ? -A : A;
  assign mag_b_in = (op[0] && B[N-1]) ? -B : B;
  assign accept   = start && (state != RUN) && op_ok;
  assign last     = (state == RUN) && (cnt == 6'(N - 1));

  assign mul_sum  = acc_hi + (acc_lo[0] ? {1'b0, opnd} : '0);
  assign prod     = neg_res ? -{mul_sum, acc_lo[N-1:1]} : {mul_sum, acc_lo[N-1:1]};

`ifdef MDU_DIVIDE_EN
  logic           is_div, neg_rem, ge;
  logic [N-1:0]   a_raw, quo;
  logic [N:0]     shifted;
  logic [N+1:0]   diff;

  assign op_ok   = 1'b1;
  assign shifted = {acc_hi[N-1:0], acc_lo[N-1]};
  assign diff    = {1'b0, shifted} - {2'b00, opnd};
  assign ge      = ~diff[N+1];
  assign quo     = {acc_lo[N-2:0], ge};

  always_comb begin
    it_hi  = {1'b0, mul_sum[N:1]};
    it_lo  = {mul_sum[0], acc_lo[N-1:1]};
    res_hi = prod[2*N-1:N];
    res_lo = prod[N-1:0];
    if (is_div) begin
      it_hi = ge ? diff[N:0] : shifted;
      it_lo = quo;
      if (opnd == '0) begin
        res_hi = a_raw;
        res_lo = '1;
      end else begin
        res_hi = neg_rem ? -it_hi[N-1:0] : it_hi[N-1:0];
        res_lo = neg_res ? -quo : quo;
      end
    end
  end
`else
  assign op_ok = ~op[1];

  always_comb begin
    it_hi  = {1'b0, mul_sum[N:1]};
    it_lo  = {mul_sum[0], acc_lo[N-1:1]};
    res_hi = prod[2*N-1:N];
    res_lo = prod[N-1:0];
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      opnd    <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      neg_res <= 1'b0;
      HI      <= '0;
      LO      <= '0;
`ifdef MDU_DIVIDE_EN
      is_div  <= 1'b0;
      neg_rem <= 1'b0;
      a_raw   <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt     <= '0;
        acc_hi  <= '0;
        neg_res <= op[0] & (A[N-1] ^ B[N-1]);
`ifdef MDU_DIVIDE_EN
        is_div  <= op[1];
        neg_rem <= op[0] & A[N-1];
        a_raw   <= A;
        opnd    <= op[1] ? mag_b_in : mag_a_in;
        acc_lo  <= op[1] ? mag_a_in : mag_b_in;
`else
        opnd    <= mag_a_in;
        acc_lo  <= mag_b_in;
`endif
      end else if (state == RUN) begin
        cnt    <= cnt + 6'd1;
        acc_hi <= it_hi;
        acc_lo <= it_lo;
        if (last) begin
          HI <= res_hi;
          LO <= res_lo;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = accept ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit: vector table, random ops, corner sequences
module tb_mult_div_unit;
  localparam int N = 32;
`ifdef MDU_DIVIDE_EN
  localparam int OPMAX = 3;
`else
  localparam int OPMAX = 1;
`endif

  logic         clk = 1'b0;
  logic         reset, start;
  logic [1:0]   op;
  logic [N-1:0] a, b, hi, lo;
  logic         busy, done;
  int           errors = 0;
  int           checks = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;
  vec_t vecs[$];

  mult_div_unit #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(a), .B(b),
    .HI(hi), .LO(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, m;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0: r = {32'b0, x} * {32'b0, y};
      2'd1: r = sx * sy;
      default: begin
        if (y == 0) r = {x, 32'hFFFFFFFF};
        else if (o == 2'd2) r = {x % y, x / y};
        else begin
          q = sx / sy;
          m = sx % sy;
          r = {m[31:0], q[31:0]};
        end
      end
    endcase
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_done(output logic [31:0] rhi, output logic [31:0] rlo, output int bcnt,
                           output bit got, output bit stable);
    logic [31:0] hold_hi, hold_lo;
    hold_hi = hi; hold_lo = lo;
    bcnt = 0; got = 0; stable = 1; rhi = '0; rlo = '0;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        got = 1; rhi = hi; rlo = lo;
        break;
      end
      if (busy) bcnt++;
      if (hi !== hold_hi || lo !== hold_lo) stable = 0;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] rhi, output logic [31:0] rlo, output int bcnt,
                       output bit got, output bit stable);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
    wait_done(rhi, rlo, bcnt, got, stable);
  endtask

  task automatic check_op(input string nm, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic [31:0] rhi, input logic [31:0] rlo, input int bcnt,
                          input bit got, input bit stable, input bit post);
    chk({nm, " done_seen"}, 64'(got), 64'd1);
    chk({nm, " busy_cycles"}, 64'(bcnt), 64'd32);
    chk({nm, " hi_lo"}, {rhi, rlo}, {ehi, elo});
    chk({nm, " hold_during_run"}, 64'(stable), 64'd1);
    if (post) begin
      @(posedge clk); #1;
      chk({nm, " done_one_cycle"}, 64'(done), 64'd0);
      chk({nm, " hold_after"}, {hi, lo}, {rhi, rlo});
    end
  endtask

  initial begin
    logic [31:0] rhi, rlo, x, y, ehi, elo;
    logic [63:0] hold;
    logic [1:0]  o;
    int          bcnt, ndone;
    bit          got, stable;

    vecs.push_back('{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
    vecs.push_back('{2'd1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1});
    vecs.push_back('{2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000});
    vecs.push_back('{2'd1, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000});
    vecs.push_back('{2'd0, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000});
`ifdef MDU_DIVIDE_EN
    vecs.push_back('{2'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{2'd2, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF});
    vecs.push_back('{2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000});
    vecs.push_back('{2'd3, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF});
    vecs.push_back('{2'd2, 32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999});
    vecs.push_back('{2'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD});
`endif

    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {busy, done, hi, lo}, {1'b0, 1'b0, 64'd0});
    #1 reset = 1'b0;

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, rhi, rlo, bcnt, got, stable);
      check_op($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo, rhi, rlo, bcnt, got, stable, 1'b1);
    end

    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, OPMAX));
      x = $urandom; y = $urandom;
      if ($urandom_range(0, 5) == 0) y = 32'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) begin x = 32'h80000000; y = 32'hFFFFFFFF; end
      {ehi, elo} = model(o, x, y);
      do_op(o, x, y, rhi, rlo, bcnt, got, stable);
      check_op($sformatf("rand%0d_op%0d", i, o), ehi, elo, rhi, rlo, bcnt, got, stable, 1'b1);
    end

    // start pulse during RUN must be ignored
    @(negedge clk);
    start = 1'b1; op = 2'd0; a = 32'd7; b = 32'd9;
    @(posedge clk); #1;
    bcnt = 0; ndone = 0; rhi = '0; rlo = '0;
    for (int k = 0; k < 45; k++) begin
      if (busy) bcnt++;
      if (done) begin ndone++; rhi = hi; rlo = lo; end
      start = (k == 4);
      if (k == 4) begin op = 2'd3; a = 32'd1; b = 32'd1; end
      @(posedge clk); #1;
    end
    chk("ignore_start busy_cycles", 64'(bcnt), 64'd32);
    chk("ignore_start done_pulses", 64'(ndone), 64'd1);
    chk("ignore_start hi_lo", {rhi, rlo}, {32'd0, 32'd63});

    // reset in the middle of a run
    @(negedge clk);
    start = 1'b1; op = 2'd0; a = 32'd7; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("abort_reset outputs", {busy, done, hi, lo}, {1'b0, 1'b0, 64'd0});
    @(posedge clk);
    #2 reset = 1'b0;
    do_op(2'd0, 32'd7, 32'd9, rhi, rlo, bcnt, got, stable);
    check_op("after_reset", 32'd0, 32'd63, rhi, rlo, bcnt, got, stable, 1'b1);

    // back-to-back start in the DONE cycle
    do_op(2'd0, 32'd2, 32'd3, rhi, rlo, bcnt, got, stable);
    check_op("b2b_first", 32'd0, 32'd6, rhi, rlo, bcnt, got, stable, 1'b0);
    start = 1'b1; op = 2'd0; a = 32'd4; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_restart state", {busy, done, lo}, {1'b1, 1'b0, 32'd6});
    wait_done(rhi, rlo, bcnt, got, stable);
    check_op("b2b_second", 32'd0, 32'd20, rhi, rlo, bcnt, got, stable, 1'b1);

`ifndef MDU_DIVIDE_EN
    hold = {hi, lo};
    @(negedge clk);
    start = 1'b1; op = 2'd2; a = 32'd100; b = 32'd0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (k == 1) op = 2'd3;
      if (k == 2) start = 1'b0;
      chk($sformatf("nodiv_reject%0d", k), {busy, done}, 64'd0);
    end
    chk("nodiv_hold", {hi, lo}, hold);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter N, default 32: operand width, also width of HI and LO.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request pulse, sampled on rising clk.
REQ-005 SHALL have port op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 SHALL have port A  input  N  multiplicand or dividend.
REQ-007 SHALL have port B  input  N  multiplier or divisor.
REQ-008 SHALL have port HI  output  N  product upper half, or remainder.
REQ-009 SHALL have port LO  output  N  product lower half, or quotient.
REQ-010 SHALL have port busy  output  1  operation in progress; pipeline enables are gated with its inverse.
REQ-011 SHALL have port done  output  1  one-cycle pulse: HI and LO were just updated.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE: IDLE->RUN on accepted start; RUN->DONE after N RUN cycles; DONE->RUN on accepted start, else DONE->IDLE.
REQ-013 SHALL accept start only in IDLE or DONE; start during RUN SHALL be ignored with no effect on state, operands or results.
REQ-014 SHALL capture A, B and op on the accepting edge; later input changes SHALL not affect the running operation.
REQ-015 SHALL hold busy=1 for exactly N cycles, from the accepting edge E0 until edge EN.
REQ-016 SHALL update HI and LO and assert done at edge EN, and SHALL deassert done at edge EN+1.
REQ-017 SHALL hold HI and LO constant at all times other than EN.
REQ-018 SHALL use one iteration per cycle: shift-add for multiply, restoring division for divide; a 6-bit counter counts N RUN cycles.
REQ-019 MULTU/MULT SHALL produce {HI,LO} = full 2N-bit product, unsigned or two's-complement signed.
REQ-020 DIVU/DIV SHALL produce LO = quotient truncated toward zero and HI = remainder; for DIV the remainder sign equals the dividend sign.
REQ-021 Signed operations SHALL operate on magnitudes, with sign correction applied on the final iteration.
REQ-022 Divide by zero (B=0) SHALL give LO = all ones and HI = A as captured, for both DIVU and DIV.
REQ-023 DIV of most-negative by -1 SHALL give LO = 0x80000000 (N=32) and HI = 0.
REQ-024 A start accepted in the DONE cycle SHALL begin the next operation back-to-back: busy=1 from that edge and done=0 after it.

Reset
REQ-025 When reset=1, SHALL immediately force state IDLE, counter 0, busy=0, done=0, HI=0, LO=0 and internal operand registers to 0.
REQ-026 Reset SHALL abort an operation in progress without any partial update of HI or LO.
REQ-027 The first start is honoured on the first rising clk after reset returns to 0.

Configuration
REQ-028 Macro MDU_DIVIDE_EN defined: all four ops SHALL be supported as above.
REQ-029 Macro MDU_DIVIDE_EN undefined: the divider datapath SHALL be omitted.
REQ-030 Macro MDU_DIVIDE_EN undefined: start with op[1]=1 SHALL not be accepted: busy and done stay 0 and HI and LO are unchanged.
REQ-031 Macro MDU_DIVIDE_EN undefined: multiply behaviour SHALL be unchanged.

Verification
REQ-032 MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> busy high exactly 32 cycles; at EN HI=0xFFFFFFFE, LO=0x00000001, done high 1 cycle.
REQ-033 MULT A=0xFFFFFFFD (-3) B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-034 DIV A=0xFFFFFFF9 (-7) B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=100 B=0 -> LO=0xFFFFFFFF, HI=0x00000064.
REQ-035 MULTU 7*9, with DIV 1/1 pulsed on start at cycle 5 of RUN -> second request ignored; LO=63, HI=0, single done pulse.
REQ-036 MULTU 7*9 started, then reset asserted at RUN cycle 10 -> busy=0, done=0, HI=LO=0 immediately; next start after release completes normally.
REQ-037 Back-to-back: MULTU 2*3, then start MULTU 4*5 in the DONE cycle -> LO=6 pulse, then LO=20 exactly 32 cycles later; with MDU_DIVIDE_EN undefined, a DIVU start keeps busy=0.
